// File: rtl/pingpong_wr_ctrl.sv
// Write-side controller for the ping-pong async FIFO (wclk domain).
// Steers a valid/ready stream into two banks in bursts of 2^ADDRSIZE.
module pingpong_wr_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATASIZE-1:0] in_data,
    output logic                in_ready,
    output logic                w_stop,
    input  logic                wfull_0,
    input  logic                wfull_1,
    input  logic                bank_free_0,
    input  logic                bank_free_1,
    input  logic                flush,
    output logic                winc_0,
    output logic                winc_1,
    output logic [DATASIZE-1:0] wdata,
    output logic                bank_done_0,
    output logic                bank_done_1,
    output logic [ADDRSIZE:0]   done_len,
    output logic                cur_bank,
    output logic                ovf_err
);

    typedef enum logic [1:0] {
        WAIT0 = 2'b00,
        FILL0 = 2'b01,
        WAIT1 = 2'b10,
        FILL1 = 2'b11
    } state_t;

    localparam logic [ADDRSIZE:0] LAST = {1'b0, {ADDRSIZE{1'b1}}};

    state_t              state_q;
    logic [ADDRSIZE:0]   cnt_q;
    logic [ADDRSIZE:0]   cnt_d;
    logic                winc0_q;
    logic                winc1_q;
    logic [DATASIZE-1:0] wdata_q;
    logic                done0_q;
    logic                done1_q;
    logic [ADDRSIZE:0]   done_len_q;
    logic                ovf_q;

    logic filling;
    logic bank;
    logic wfull_cur;
    logic acc;
    logic close;

    // state encoding: bit0 = filling, bit1 = bank
    assign filling   = state_q[0];
    assign bank      = state_q[1];
    assign wfull_cur = bank ? wfull_1 : wfull_0;

    assign in_ready = filling & ~wfull_cur;
    assign w_stop   = ~in_ready;
    assign acc      = in_valid & in_ready;
    assign cnt_d    = cnt_q + {{ADDRSIZE{1'b0}}, acc};

    assign close = filling &
                   ((acc & (cnt_q == LAST)) |
                    (flush & (cnt_d != '0)));

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT0;
            cnt_q      <= '0;
            winc0_q    <= 1'b0;
            winc1_q    <= 1'b0;
            wdata_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            done_len_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            winc0_q <= acc & ~bank;
            winc1_q <= acc & bank;
            if (acc)
                wdata_q <= in_data;
            done0_q <= close & ~bank;
            done1_q <= close & bank;
            if (close)
                done_len_q <= cnt_d;
            if (filling & wfull_cur & (cnt_q <= LAST))
                ovf_q <= 1'b1;
            cnt_q <= close ? '0 : cnt_d;
            unique case (state_q)
                WAIT0: if (bank_free_0) state_q <= FILL0;
                FILL0: if (close)
                    state_q <= bank_free_1 ? FILL1 : WAIT1;
                WAIT1: if (bank_free_1) state_q <= FILL1;
                FILL1: if (close)
                    state_q <= bank_free_0 ? FILL0 : WAIT0;
            endcase
        end
    end

    assign winc_0      = winc0_q;
    assign winc_1      = winc1_q;
    assign wdata       = wdata_q;
    assign bank_done_0 = done0_q;
    assign bank_done_1 = done1_q;
    assign done_len    = done_len_q;
    assign cur_bank    = bank;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Directed bench for pingpong_wr_ctrl: bursts, stalls,
// flush, overflow, mid-burst reset and random gaps.
module tb_pingpong_wr_ctrl;

    logic       wclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       w_stop;
    logic       wfull_0 = 1'b0;
    logic       wfull_1 = 1'b0;
    logic       bank_free_0 = 1'b0;
    logic       bank_free_1 = 1'b0;
    logic       flush = 1'b0;
    logic       winc_0;
    logic       winc_1;
    logic [7:0] wdata;
    logic       bank_done_0;
    logic       bank_done_1;
    logic [4:0] done_len;
    logic       cur_bank;
    logic       ovf_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int mon_data[$];
    int mon_bank[$];
    int mon_cyc[$];
    int dn_bank[$];
    int dn_len[$];

    pingpong_wr_ctrl #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .wclk(wclk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .w_stop(w_stop),
        .wfull_0(wfull_0),
        .wfull_1(wfull_1),
        .bank_free_0(bank_free_0),
        .bank_free_1(bank_free_1),
        .flush(flush),
        .winc_0(winc_0),
        .winc_1(winc_1),
        .wdata(wdata),
        .bank_done_0(bank_done_0),
        .bank_done_1(bank_done_1),
        .done_len(done_len),
        .cur_bank(cur_bank),
        .ovf_err(ovf_err)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge wclk) begin
        if (winc_0 || winc_1) begin
            mon_data.push_back(int'(wdata));
            mon_bank.push_back(int'(winc_1));
            mon_cyc.push_back(cyc);
            chk("overlap", {31'd0, winc_0 & winc_1}, 32'd0);
        end
        if (bank_done_0 || bank_done_1) begin
            dn_bank.push_back(int'(bank_done_1));
            dn_len.push_back(int'(done_len));
        end
    end

    task automatic clr();
        mon_data.delete();
        mon_bank.delete();
        mon_cyc.delete();
        dn_bank.delete();
        dn_len.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge wclk);
        #1;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_winc0"}, {31'd0, winc_0}, 0);
        chk({tag, "_winc1"}, {31'd0, winc_1}, 0);
        chk({tag, "_wdata"}, {24'd0, wdata}, 0);
        chk({tag, "_done"}, {30'd0, bank_done_1, bank_done_0}, 0);
        chk({tag, "_len"}, {27'd0, done_len}, 0);
        chk({tag, "_bank"}, {31'd0, cur_bank}, 0);
        chk({tag, "_ovf"}, {31'd0, ovf_err}, 0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 0);
        chk({tag, "_stop"}, {31'd0, w_stop}, 1);
    endtask

    task automatic do_reset();
        @(negedge wclk);
        rst_n = 1'b0;
        #2;
        chk_rst("rst");
        @(negedge wclk);
        rst_n = 1'b1;
    endtask

    // Offer one word and hold it until accepted or maxw cycles pass.
    task automatic push(input int d, input int maxw);
        int w;
        in_valid = 1'b1;
        in_data  = d[7:0];
        w = 0;
        forever begin
            @(negedge wclk);
            if (in_ready) break;
            w++;
            if (w > maxw) begin
                chk("push_timeout", 1, 0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge wclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_mon(input string tag, input int idx,
                           input int d, input int b);
        if (idx >= mon_data.size()) begin
            chk({tag, "_missing"}, idx, mon_data.size());
            return;
        end
        chk({tag, "_data"}, mon_data[idx], d);
        chk({tag, "_bank"}, mon_bank[idx], b);
    endtask

    task automatic chk_dn(input string tag, input int idx,
                          input int b, input int len);
        if (idx >= dn_len.size()) begin
            chk({tag, "_missing"}, idx, dn_len.size());
            return;
        end
        chk({tag, "_bank"}, dn_bank[idx], b);
        chk({tag, "_len"}, dn_len[idx], len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[$];
        int d;

        // 1: three back-to-back bursts, both banks free
        bank_free_0 = 1'b1;
        bank_free_1 = 1'b1;
        do_reset();
        clr();
        for (int i = 0; i < 48; i++) push(i, 4);
        idle(3);
        chk("t1_count", mon_data.size(), 48);
        for (int i = 0; i < 48; i++)
            chk_mon("t1", i, i, (i / 16) % 2);
        if (mon_cyc.size() == 48)
            chk("t1_nobubble", mon_cyc[47] - mon_cyc[0], 47);
        chk("t1_ndone", dn_len.size(), 3);
        chk_dn("t1_d0", 0, 0, 16);
        chk_dn("t1_d1", 1, 1, 16);
        chk_dn("t1_d2", 2, 0, 16);

        // 2: bank 1 not free for 30 cycles after bank 0 closes
        bank_free_1 = 1'b0;
        do_reset();
        clr();
        for (int i = 0; i < 16; i++) push(i, 4);
        in_valid = 1'b1;
        in_data  = 8'd16;
        for (int i = 0; i < 30; i++) begin
            @(negedge wclk);
            chk("t2_stop", {31'd0, w_stop}, 1);
        end
        bank_free_1 = 1'b1;
        push(16, 5);
        idle(3);
        chk("t2_count", mon_data.size(), 17);
        chk_mon("t2_last", 15, 15, 0);
        chk_mon("t2_held", 16, 16, 1);
        chk_dn("t2_d0", 0, 0, 16);

        // 3: flush after five words
        do_reset();
        clr();
        for (int i = 0; i < 5; i++) push(i, 4);
        flush = 1'b1;
        @(posedge wclk);
        #1;
        flush = 1'b0;
        chk("t3_bank", {31'd0, cur_bank}, 1);
        push(5, 4);
        idle(3);
        chk_dn("t3_d0", 0, 0, 5);
        chk("t3_ndone", dn_len.size(), 1);
        chk_mon("t3_next", 5, 5, 1);
        chk("t3_ovf", {31'd0, ovf_err}, 0);

        // 4: wfull_0 forced at cnt = 7 for four cycles
        do_reset();
        clr();
        for (int i = 0; i < 7; i++) push(i, 4);
        wfull_0  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            chk("t4_rdy", {31'd0, in_ready}, 0);
            @(posedge wclk);
        end
        #1;
        wfull_0 = 1'b0;
        chk("t4_ovf", {31'd0, ovf_err}, 1);
        for (int i = 7; i < 16; i++) push(i, 4);
        idle(3);
        chk("t4_count", mon_data.size(), 16);
        for (int i = 0; i < 16; i++) chk_mon("t4", i, i, 0);
        chk_dn("t4_d0", 0, 0, 16);
        chk("t4_ovf_sticky", {31'd0, ovf_err}, 1);

        // 5: asynchronous reset at cnt = 9
        do_reset();
        clr();
        for (int i = 0; i < 9; i++) push(200 + i, 4);
        chk("t5_pre", {31'd0, winc_0}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rst("t5_async");
        @(negedge wclk);
        rst_n = 1'b1;
        idle(2);
        chk("t5_nodone", dn_len.size(), 0);
        clr();
        for (int i = 0; i < 16; i++) push(100 + i, 4);
        idle(3);
        chk_mon("t5_first", 0, 100, 0);
        chk("t5_ndone", dn_len.size(), 1);
        chk_dn("t5_d0", 0, 0, 16);

        // 6: 100 words with random valid gaps
        do_reset();
        clr();
        for (int i = 0; i < 100; i++) begin
            d = (i * 37 + 11) % 256;
            seq.push_back(d);
            if ($urandom_range(0, 1) == 1) idle(1);
            push(d, 4);
        end
        idle(3);
        chk("t6_count", mon_data.size(), 100);
        for (int i = 0; i < 100; i++) begin
            if (i < mon_data.size())
                chk("t6_data", mon_data[i], seq[i]);
        end
        chk("t6_ndone", dn_len.size(), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
